uart_tx_ctrl: RTL

UART transmit controller that sequences one 8-bit character per frame onto the serial line: start bit, 8 data bits LSB-first, optional parity bit, and stop bit. It owns the accept handshake with the upstream byte source, latches per-frame parity configuration, and generates bit timing from the system clock. It sits between the TX byte source (FIFO or register interface) and the `tx` pin. Parity generation is internal to this block.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_bit_timer.sv | 36 +++
 rtl/uart_tx_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame payload and line levels.
// Used by the TX controller and intended for the future RX controller.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_IDX_W     = $clog2(UART_DATA_BITS);

  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;
  localparam logic UART_IDLE_LVL  = 1'b1;

  localparam logic [2:0] UART_ST_IDLE   = 3'd0;
  localparam logic [2:0] UART_ST_START  = 3'd1;
  localparam logic [2:0] UART_ST_DATA   = 3'd2;
  localparam logic [2:0] UART_ST_PARITY = 3'd3;
  localparam logic [2:0] UART_ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = UART_ST_IDLE,
    ST_START  = UART_ST_START,
    ST_DATA   = UART_ST_DATA,
    ST_PARITY = UART_ST_PARITY,
    ST_STOP   = UART_ST_STOP
  } uart_state_e;

  // Per-frame configuration captured at accept.
  typedef struct packed {
    logic [UART_DATA_BITS-1:0] data;
    logic                      parity_en;
    logic                      parity_bit;
  } uart_frame_t;

  // Parity bit that makes data+parity even (odd=0) or odd (odd=1).
  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
// A clear restarts the period so the first bit after accept is full length.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt + CNT_W'(1);
    if (clear || (cnt == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  // bit_end is registered from the next count so it is high while cnt == CNT_LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_end <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      bit_end <= (cnt_d == CNT_LAST);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start, 8 data bits LSB-first, optional parity, stop.
// Handshakes one byte per frame from the upstream source and drives the tx pin.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       parity_en,
  input  logic       parity_odd,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [UART_IDX_W-1:0] LAST_IDX = UART_IDX_W'(UART_DATA_BITS - 1);

  uart_state_e             state, state_d;
  uart_frame_t             frame_q, frame_d;
  logic [UART_IDX_W-1:0]   bit_idx, bit_idx_d;
  logic                    tx_d;
  logic                    busy_d;
  logic                    frame_done_d;
  logic                    timer_clear;
  logic                    bit_end;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  assign tx_ready = (state == ST_IDLE);

  // Next-state logic; outputs are derived from the next state so they register on the same edge.
  always_comb begin
    state_d      = state;
    frame_d      = frame_q;
    bit_idx_d    = bit_idx;
    timer_clear  = 1'b0;
    frame_done_d = 1'b0;
    tx_d         = UART_IDLE_LVL;

    unique case (state)
      ST_IDLE: begin
        if (tx_valid) begin
          frame_d.data       = tx_data;
          frame_d.parity_en  = parity_en;
          frame_d.parity_bit = uart_parity(tx_data, parity_odd);
          bit_idx_d          = '0;
          timer_clear        = 1'b1;
          state_d            = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == LAST_IDX) begin
            state_d = frame_q.parity_en ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx + UART_IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    unique case (state_d)
      ST_IDLE:   tx_d = UART_IDLE_LVL;
      ST_START:  tx_d = UART_START_LVL;
      ST_DATA:   tx_d = frame_d.data[bit_idx_d];
      ST_PARITY: tx_d = frame_d.parity_bit;
      ST_STOP:   tx_d = UART_STOP_LVL;
      default:   tx_d = UART_IDLE_LVL;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      frame_q    <= '0;
      bit_idx    <= '0;
      tx         <= UART_IDLE_LVL;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      frame_q    <= frame_d;
      bit_idx    <= bit_idx_d;
      tx         <= tx_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

endmodule
